// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Hardwired control unit for the 32-bit bus-based CPU datapath. A T-state
// machine (T0..T7 plus HALT) steps through fetch and the execute sequence
// selected by the opcode in IR[31:27]. Each state lasts one cycle, and the
// strobes are a Moore decode of the state, the opcode and CON.
//
// Ports:
//   Clock                        system clock, rising edge
//   Clear                        synchronous active-high reset (to T0, Run=1)
//   IR[31:0]                     instruction register, opcode = IR[31:27]
//   CON                          branch condition flag, used in br T6 only
//   PCout..Cout                  bus-drive selects (at most one high)
//   MARin..CONIn                 register load enables
//   Gra, Grb, Grc                register-field selects
//   IncPC, Read, Write           PC increment and memory strobes
//   ADD, SUB, AND, OR            one-hot ALU operation select
//   Run                          high while executing, low in HALT
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        CONIn,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        IncPC,
    output logic        Read,
    output logic        Write,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        Run
);

    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, HALT} state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01011;
    localparam logic [4:0] OP_ANDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01101;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10011;
    localparam logic [4:0] OP_HALT = 5'b11010;

    state_t     r_state;
    state_t     w_next;
    logic [4:0] w_op;
    logic       w_isAlu, w_isImm, w_isLdi, w_isLd, w_isSt, w_isBr, w_isJr, w_isHalt;
    logic       w_selAdd, w_selSub, w_selAnd, w_selOr;
    logic       w_unusedIr;

    assign w_op       = IR[31:27];
    assign w_unusedIr = ^IR[26:0];

    assign w_isAlu  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_AND) || (w_op == OP_OR);
    assign w_isImm  = (w_op == OP_ADDI) || (w_op == OP_ANDI) || (w_op == OP_ORI);
    assign w_isLdi  = (w_op == OP_LDI);
    assign w_isLd   = (w_op == OP_LD);
    assign w_isSt   = (w_op == OP_ST);
    assign w_isBr   = (w_op == OP_BR);
    assign w_isJr   = (w_op == OP_JR);
    assign w_isHalt = (w_op == OP_HALT);

    // ALU operation for the register and immediate forms in T4
    assign w_selAdd = (w_op == OP_ADD) || (w_op == OP_ADDI);
    assign w_selSub = (w_op == OP_SUB);
    assign w_selAnd = (w_op == OP_AND) || (w_op == OP_ANDI);
    assign w_selOr  = (w_op == OP_OR)  || (w_op == OP_ORI);

    // State register; Clear takes effect at the edge from any state
    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= T0;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: fetch is fixed, then the opcode picks the sequence length
    always_comb begin
        w_next = T0;
        case (r_state)
            T0:   w_next = T1;
            T1:   w_next = T2;
            T2:   w_next = T3;
            T3: begin
                if (w_isHalt) begin
                    w_next = HALT;
                end else if (w_isAlu || w_isImm || w_isLdi || w_isLd || w_isSt || w_isBr) begin
                    w_next = T4;
                end else begin
                    w_next = T0;
                end
            end
            T4:   w_next = T5;
            T5:   w_next = (w_isLd || w_isSt || w_isBr) ? T6 : T0;
            T6:   w_next = (w_isLd || w_isSt) ? T7 : T0;
            T7:   w_next = T0;
            HALT: w_next = HALT;
            default: w_next = T0;
        endcase
    end

    // Output decode; Clear blanks every strobe regardless of state
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Rin = 1'b0; CONIn = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        ADD = 1'b0; SUB = 1'b0; AND = 1'b0; OR = 1'b0;
        Run = (r_state != HALT);
        if (!Clear) begin
            case (r_state)
                T0: begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
                end
                T1: begin
                    Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
                end
                T2: begin
                    MDRout = 1'b1; IRin = 1'b1;
                end
                T3: begin
                    if (w_isAlu || w_isImm) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (w_isLdi || w_isLd || w_isSt) begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end else if (w_isBr) begin
                        Gra = 1'b1; Rout = 1'b1; CONIn = 1'b1;
                    end else if (w_isJr) begin
                        Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
                    end
                end
                T4: begin
                    if (w_isAlu) begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                        ADD = w_selAdd; SUB = w_selSub; AND = w_selAnd; OR = w_selOr;
                    end else if (w_isImm) begin
                        Cout = 1'b1; Zin = 1'b1;
                        ADD = w_selAdd; SUB = w_selSub; AND = w_selAnd; OR = w_selOr;
                    end else if (w_isLdi || w_isLd || w_isSt) begin
                        Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                    end else if (w_isBr) begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                end
                T5: begin
                    if (w_isAlu || w_isImm || w_isLdi) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (w_isLd || w_isSt) begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end else if (w_isBr) begin
                        Cout = 1'b1; ADD = 1'b1; Zin = 1'b1;
                    end
                end
                T6: begin
                    if (w_isLd) begin
                        Read = 1'b1; MDRin = 1'b1;
                    end else if (w_isSt) begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end else if (w_isBr && CON) begin
                        Zlowout = 1'b1; PCin = 1'b1;
                    end
                end
                T7: begin
                    if (w_isLd) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (w_isSt) begin
                        Write = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//
// Self-checking bench for control_sequencer. Each test task queues the
// expected 25-bit strobe vector for every cycle of an instruction, then
// steps the clock and compares the DUT against the popped entries.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic [31:0] IR;
    logic        CON;
    logic PCout, Zlowout, MDRout, Rout, BAout, Cout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONIn;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic ADD, SUB, AND, OR, Run;

    logic [24:0] w_obs;
    logic [24:0] q[$];
    int          checks = 0;
    int          errors = 0;

    localparam logic [24:0] M_PCOUT   = 25'd1 << 24;
    localparam logic [24:0] M_ZLOWOUT = 25'd1 << 23;
    localparam logic [24:0] M_MDROUT  = 25'd1 << 22;
    localparam logic [24:0] M_ROUT    = 25'd1 << 21;
    localparam logic [24:0] M_BAOUT   = 25'd1 << 20;
    localparam logic [24:0] M_COUT    = 25'd1 << 19;
    localparam logic [24:0] M_MARIN   = 25'd1 << 18;
    localparam logic [24:0] M_ZIN     = 25'd1 << 17;
    localparam logic [24:0] M_PCIN    = 25'd1 << 16;
    localparam logic [24:0] M_MDRIN   = 25'd1 << 15;
    localparam logic [24:0] M_IRIN    = 25'd1 << 14;
    localparam logic [24:0] M_YIN     = 25'd1 << 13;
    localparam logic [24:0] M_RIN     = 25'd1 << 12;
    localparam logic [24:0] M_CONIN   = 25'd1 << 11;
    localparam logic [24:0] M_GRA     = 25'd1 << 10;
    localparam logic [24:0] M_GRB     = 25'd1 << 9;
    localparam logic [24:0] M_GRC     = 25'd1 << 8;
    localparam logic [24:0] M_INCPC   = 25'd1 << 7;
    localparam logic [24:0] M_READ    = 25'd1 << 6;
    localparam logic [24:0] M_WRITE   = 25'd1 << 5;
    localparam logic [24:0] M_ADD     = 25'd1 << 4;
    localparam logic [24:0] M_SUB     = 25'd1 << 3;
    localparam logic [24:0] M_AND     = 25'd1 << 2;
    localparam logic [24:0] M_OR      = 25'd1 << 1;
    localparam logic [24:0] M_RUN     = 25'd1;

    localparam logic [24:0] V_T0 = M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [24:0] V_T1 = M_RUN | M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
    localparam logic [24:0] V_T2 = M_RUN | M_MDROUT | M_IRIN;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON),
        .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
        .BAout(BAout), .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin),
        .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .CONIn(CONIn),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read),
        .Write(Write), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Run(Run)
    );

    assign w_obs = {PCout, Zlowout, MDRout, Rout, BAout, Cout,
                    MARin, Zin, PCin, MDRin, IRin, Yin, Rin, CONIn,
                    Gra, Grb, Grc, IncPC, Read, Write,
                    ADD, SUB, AND, OR, Run};

    // Free-running clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Hard time limit so a stuck run still reports
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Step to just after the next rising edge
    task automatic advance();
        @(posedge Clock);
        #1;
    endtask

    // Queue the three fetch cycles shared by every instruction
    task automatic pushFetch();
        q.push_back(V_T0);
        q.push_back(V_T1);
        q.push_back(V_T2);
    endtask

    // Clear held for two cycles: only Run, then T0 strobes once released
    task automatic test_reset();
        logic [24:0] exp;
        Clear = 1'b1;
        IR    = 32'h0;
        CON   = 1'b0;
        q.push_back(M_RUN);
        q.push_back(M_RUN);
        for (int i = 0; i < 2; i++) begin
            advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL reset cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
        Clear = 1'b0;
        #1;
        checks++;
        if (w_obs !== V_T0) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", w_obs, V_T0);
        end
    endtask

    // addi R2,R1,-5 followed by the return to T0 on cycle 7
    task automatic test_addi();
        logic [24:0] exp;
        IR = 32'h590FFFFB;
        pushFetch();
        q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
        q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
        q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
        q.push_back(V_T0);
        for (int i = 0; q.size() > 0; i++) begin
            if (i > 0) advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL addi cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
    endtask

    // Register and immediate ALU forms plus ldi, each 6 cycles
    task automatic test_alu();
        logic [24:0] exp;
        logic [4:0]  ops   [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                   5'b01011, 5'b01100, 5'b01101, 5'b00001};
        logic [24:0] sel   [8] = '{M_ADD, M_SUB, M_AND, M_OR, M_ADD, M_AND, M_OR, M_ADD};
        for (int k = 0; k < 8; k++) begin
            IR = {ops[k], 27'($urandom)};
            pushFetch();
            if (k < 4) begin
                q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                q.push_back(M_RUN | M_GRC | M_ROUT | M_ZIN | sel[k]);
            end else if (k < 7) begin
                q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                q.push_back(M_RUN | M_COUT | M_ZIN | sel[k]);
            end else begin
                q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
                q.push_back(M_RUN | M_COUT | M_ZIN | sel[k]);
            end
            q.push_back(M_RUN | M_ZLOWOUT | M_GRA | M_RIN);
            q.push_back(V_T0);
            for (int i = 0; q.size() > 0; i++) begin
                if (i > 0) advance();
                exp = q.pop_front();
                checks++;
                if (w_obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL alu op=%b cycle %0d: got %h expected %h", ops[k], i, w_obs, exp);
                end
            end
        end
    endtask

    // ld: 8-cycle period, memory read in T6, no Write anywhere
    task automatic test_ld();
        logic [24:0] exp;
        IR = 32'h00800000;
        pushFetch();
        q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
        q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
        q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
        q.push_back(M_RUN | M_READ | M_MDRIN);
        q.push_back(M_RUN | M_MDROUT | M_GRA | M_RIN);
        q.push_back(V_T0);
        for (int i = 0; q.size() > 0; i++) begin
            if (i > 0) advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL ld cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
    endtask

    // Complete st: data staged in T6 without Read, Write in T7
    task automatic test_st();
        logic [24:0] exp;
        IR = 32'h10000000;
        pushFetch();
        q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
        q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
        q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
        q.push_back(M_RUN | M_GRA | M_ROUT | M_MDRIN);
        q.push_back(M_RUN | M_WRITE);
        q.push_back(V_T0);
        for (int i = 0; q.size() > 0; i++) begin
            if (i > 0) advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL st cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
    endtask

    // br taken and not taken, 7 cycles either way
    task automatic test_br();
        logic [24:0] exp;
        IR = 32'h90000000;
        for (int c = 1; c >= 0; c--) begin
            CON = c[0];
            pushFetch();
            q.push_back(M_RUN | M_GRA | M_ROUT | M_CONIN);
            q.push_back(M_RUN | M_PCOUT | M_YIN);
            q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
            q.push_back(c[0] ? (M_RUN | M_ZLOWOUT | M_PCIN) : M_RUN);
            q.push_back(V_T0);
            for (int i = 0; q.size() > 0; i++) begin
                if (i > 0) advance();
                exp = q.pop_front();
                checks++;
                if (w_obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL br con=%0d cycle %0d: got %h expected %h", c, i, w_obs, exp);
                end
            end
        end
        CON = 1'b0;
    endtask

    // jr, nop and an unlisted opcode all finish in 4 cycles
    task automatic test_short();
        logic [24:0] exp;
        logic [4:0]  ops [3] = '{5'b10011, 5'b11001, 5'b11111};
        for (int k = 0; k < 3; k++) begin
            IR = {ops[k], 27'h1234567};
            pushFetch();
            q.push_back((k == 0) ? (M_RUN | M_GRA | M_ROUT | M_PCIN) : M_RUN);
            q.push_back(V_T0);
            for (int i = 0; q.size() > 0; i++) begin
                if (i > 0) advance();
                exp = q.pop_front();
                checks++;
                if (w_obs !== exp) begin
                    errors++;
                    $display("[TB] FAIL short op=%b cycle %0d: got %h expected %h", ops[k], i, w_obs, exp);
                end
            end
        end
    endtask

    // halt parks with Run=0 until Clear brings back T0
    task automatic test_halt();
        logic [24:0] exp;
        IR = 32'hD0000000;
        pushFetch();
        q.push_back(M_RUN);
        for (int j = 0; j < 20; j++) q.push_back(25'd0);
        for (int i = 0; q.size() > 0; i++) begin
            if (i > 0) advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL halt cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
        Clear = 1'b1;
        #1;
        checks++;
        if (w_obs !== 25'd0) begin
            errors++;
            $display("[TB] FAIL halt_clear_pre: got %h expected %h", w_obs, 25'd0);
        end
        advance();
        checks++;
        if (w_obs !== M_RUN) begin
            errors++;
            $display("[TB] FAIL halt_clear_edge: got %h expected %h", w_obs, M_RUN);
        end
        Clear = 1'b0;
        #1;
        checks++;
        if (w_obs !== V_T0) begin
            errors++;
            $display("[TB] FAIL halt_restart: got %h expected %h", w_obs, V_T0);
        end
    endtask

    // Clear during st T5 aborts before MDRin or Write can pulse
    task automatic test_clear_st();
        logic [24:0] exp;
        IR = 32'h10000000;
        pushFetch();
        q.push_back(M_RUN | M_GRB | M_BAOUT | M_YIN);
        q.push_back(M_RUN | M_COUT | M_ADD | M_ZIN);
        q.push_back(M_RUN | M_ZLOWOUT | M_MARIN);
        for (int i = 0; q.size() > 0; i++) begin
            if (i > 0) advance();
            exp = q.pop_front();
            checks++;
            if (w_obs !== exp) begin
                errors++;
                $display("[TB] FAIL clear_st cycle %0d: got %h expected %h", i, w_obs, exp);
            end
        end
        Clear = 1'b1;
        advance();
        checks++;
        if (w_obs !== M_RUN) begin
            errors++;
            $display("[TB] FAIL clear_st_abort: got %h expected %h", w_obs, M_RUN);
        end
        IR    = 32'hC8000000;
        Clear = 1'b0;
        #1;
        checks++;
        if (w_obs !== V_T0) begin
            errors++;
            $display("[TB] FAIL clear_st_restart: got %h expected %h", w_obs, V_T0);
        end
        advance();
        checks++;
        if ((Write !== 1'b0) || (w_obs !== V_T1)) begin
            errors++;
            $display("[TB] FAIL clear_st_t1: got %h expected %h", w_obs, V_T1);
        end
    endtask

    // Test sequence
    initial begin
        Clear = 1'b1;
        IR    = 32'h0;
        CON   = 1'b0;
        test_reset();
        test_addi();
        test_alu();
        test_ld();
        test_st();
        test_br();
        test_short();
        test_halt();
        test_clear_st();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
